driver_core_loader: RTL



---
 rtl/driver_core_loader_if.sv | 42 ++++
 rtl/driver_core_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/driver_core_loader_if.sv
// Command handshake plus the registered driver_core "_a" bus, grouped for the loader.
// The loader (slave) consumes commands and drives the core bus; the source (master) drives commands.
interface driver_core_loader_if #(
  parameter int MAL = 6
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [MAL-1:0]  cmd_addr;
  logic [15:0]     cmd_data;
  logic            busy;
  logic            err_illegal;

  logic [2:0]      mask_select_a;
  logic [MAL-1:0]  mem_address_a;
  logic            mem_write_n_a;
  logic            mem_dot_write_n_a;
  logic [MAL-1:0]  row_select_a;
  logic [MAL-1:0]  col_select_a;
  logic [MAL-1:0]  mem_sel_col_address_a;
  logic [15:0]     data_in_a;
  logic            mem_sel_write_n_a;
  logic            row_col_select_a;
  logic            output_active_a;
  logic            inverter_select_a;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, busy, err_illegal,
    input  mask_select_a, mem_address_a, mem_write_n_a, mem_dot_write_n_a,
    input  row_select_a, col_select_a, mem_sel_col_address_a, data_in_a,
    input  mem_sel_write_n_a, row_col_select_a, output_active_a, inverter_select_a
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, busy, err_illegal,
    output mask_select_a, mem_address_a, mem_write_n_a, mem_dot_write_n_a,
    output row_select_a, col_select_a, mem_sel_col_address_a, data_in_a,
    output mem_sel_write_n_a, row_col_select_a, output_active_a, inverter_select_a
  );
endinterface

// File: rtl/driver_core_loader.sv
// Sequences configuration and memory-load commands into one driver_core, framing every
// write with setup/strobe/hold windows so the core samples stable address and data.
module driver_core_loader #(
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int SETUP_CYCLES       = 4,
  parameter int STROBE_CYCLES      = 4,
  parameter int HOLD_CYCLES        = 4,
  parameter bit BLANK_ON_WRITE     = 1'b1
) (
  input logic                 clock_i,
  input logic                 reset_i,
  driver_core_loader_if.slave bus
);
  // state  | meaning
  // IDLE   | ready for a command
  // SETUP  | write fields stable, strobe still high
  // STROBE | selected write strobe low
  // HOLD   | fields held after the strobe, or static-op settle time
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_e;

  localparam int            MAL       = MEM_ADDRESS_LENGTH;
  localparam int            CW        = 16;
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

  localparam logic [1:0] W_MEM  = 2'd0;
  localparam logic [1:0] W_DOT  = 2'd1;
  localparam logic [1:0] W_SEL  = 2'd2;
  localparam logic [1:0] W_NONE = 2'd3;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     wop_q, wop_d;
  logic [MAL-1:0] mem_addr_q, mem_addr_d, row_q, row_d, col_q, col_d, sel_col_q, sel_col_d;
  logic [15:0]    data_q, data_d;
  logic [2:0]     mask_q, mask_d;
  logic           rcs_q, rcs_d, inv_q, inv_d, act_q, act_d, oa_q, oa_d, err_q, err_d;
  logic           wr_n_q, wr_n_d, dot_n_q, dot_n_d, sel_n_q, sel_n_d;
  logic           ready, accept;

  assign ready  = (state_q == S_IDLE) && !reset_i;
  assign accept = bus.cmd_valid && ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wop_d      = wop_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    sel_col_d  = sel_col_q;
    rcs_d      = rcs_q;
    row_d      = row_q;
    col_d      = col_q;
    mask_d     = mask_q;
    inv_d      = inv_q;
    act_d      = act_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            3'd0, 3'd1: begin
              mem_addr_d = bus.cmd_addr;
              data_d     = bus.cmd_data;
              wop_d      = (bus.cmd_op == 3'd0) ? W_MEM : W_DOT;
              state_d    = S_SETUP;
              cnt_d      = SETUP_LD;
            end
            3'd2: begin
              sel_col_d = bus.cmd_addr;
              rcs_d     = bus.cmd_data[0];
              wop_d     = W_SEL;
              state_d   = S_SETUP;
              cnt_d     = SETUP_LD;
            end
            3'd3: begin
              row_d   = bus.cmd_addr;
              col_d   = bus.cmd_data[MAL-1:0];
              wop_d   = W_NONE;
              state_d = S_HOLD;
              cnt_d   = HOLD_LD;
            end
            3'd4: begin
              mask_d  = bus.cmd_data[2:0];
              inv_d   = bus.cmd_data[3];
              act_d   = bus.cmd_data[4];
              wop_d   = W_NONE;
              state_d = S_HOLD;
              cnt_d   = HOLD_LD;
            end
            // Illegal ops are consumed in place; only the sticky flag changes.
            default: err_d = 1'b1;
          endcase
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes and blanking are decoded from the next state so they register glitch-free.
    wr_n_d  = !((state_d == S_STROBE) && (wop_d == W_MEM));
    dot_n_d = !((state_d == S_STROBE) && (wop_d == W_DOT));
    sel_n_d = !((state_d == S_STROBE) && (wop_d == W_SEL));
    oa_d    = (BLANK_ON_WRITE && (state_d != S_IDLE) && (wop_d != W_NONE)) ? 1'b0 : act_d;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wop_q      <= W_NONE;
      mem_addr_q <= '0;
      data_q     <= '0;
      sel_col_q  <= '0;
      rcs_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      mask_q     <= '0;
      inv_q      <= 1'b0;
      act_q      <= 1'b0;
      oa_q       <= 1'b0;
      err_q      <= 1'b0;
      wr_n_q     <= 1'b1;
      dot_n_q    <= 1'b1;
      sel_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wop_q      <= wop_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
      sel_col_q  <= sel_col_d;
      rcs_q      <= rcs_d;
      row_q      <= row_d;
      col_q      <= col_d;
      mask_q     <= mask_d;
      inv_q      <= inv_d;
      act_q      <= act_d;
      oa_q       <= oa_d;
      err_q      <= err_d;
      wr_n_q     <= wr_n_d;
      dot_n_q    <= dot_n_d;
      sel_n_q    <= sel_n_d;
    end
  end

  assign bus.cmd_ready             = ready;
  assign bus.busy                  = (state_q != S_IDLE);
  assign bus.err_illegal           = err_q;
  assign bus.mask_select_a         = mask_q;
  assign bus.mem_address_a         = mem_addr_q;
  assign bus.mem_write_n_a         = wr_n_q;
  assign bus.mem_dot_write_n_a     = dot_n_q;
  assign bus.row_select_a          = row_q;
  assign bus.col_select_a          = col_q;
  assign bus.mem_sel_col_address_a = sel_col_q;
  assign bus.data_in_a             = data_q;
  assign bus.mem_sel_write_n_a     = sel_n_q;
  assign bus.row_col_select_a      = rcs_q;
  assign bus.output_active_a       = oa_q;
  assign bus.inverter_select_a     = inv_q;
endmodule
